// File: rtl/alu_pkg.sv
// Shared ALU mode codes, RV32I opcodes, issue FSM states and decode record.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_LTU  = 4'd8;
    localparam logic [3:0] ALU_GEU  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NE   = 4'd11;
    localparam logic [3:0] ALU_LT   = 4'd12;
    localparam logic [3:0] ALU_GE   = 4'd13;
    localparam logic [3:0] ALU_IDLE = 4'hF;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_EXEC, ST_DONE} state_t;
    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_t;
    typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} b_sel_t;

    typedef struct packed {
        logic [3:0] mode;
        a_sel_t     a_sel;
        b_sel_t     b_sel;
        logic       rd_we;
        logic       is_branch;
        logic       is_jump;
        logic       illegal;
    } dec_t;

    function automatic logic is_shift(input logic [3:0] mode);
        return (mode == ALU_SLL) || (mode == ALU_SRL) || (mode == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I field decode into ALU mode, operand selects and result flags.
module alu_decode
    import alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output dec_t       o_dec
);

    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch behind.
        o_dec.mode      = ALU_ADD;
        o_dec.a_sel     = A_RS1;
        o_dec.b_sel     = B_IMM;
        o_dec.rd_we     = 1'b0;
        o_dec.is_branch = 1'b0;
        o_dec.is_jump   = 1'b0;
        o_dec.illegal   = 1'b0;
        case (i_opcode)
            OPC_OP, OPC_OPIMM: begin
                o_dec.rd_we = 1'b1;
                if (i_opcode == OPC_OP) o_dec.b_sel = B_RS2;
                case (i_funct3)
                    3'b000:  o_dec.mode = (i_opcode == OPC_OP && i_funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_dec.mode = ALU_SLL;
                    3'b010:  o_dec.mode = ALU_LT;
                    3'b011:  o_dec.mode = ALU_LTU;
                    3'b100:  o_dec.mode = ALU_XOR;
                    3'b101:  o_dec.mode = i_funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  o_dec.mode = ALU_OR;
                    default: o_dec.mode = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                o_dec.a_sel = A_ZERO;
                o_dec.rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                o_dec.a_sel = A_PC;
                o_dec.rd_we = 1'b1;
            end
            OPC_LOAD:  o_dec.rd_we = 1'b1;
            OPC_STORE: o_dec.rd_we = 1'b0;
            OPC_BRANCH: begin
                o_dec.b_sel     = B_RS2;
                o_dec.is_branch = 1'b1;
                case (i_funct3)
                    3'b000:  o_dec.mode = ALU_EQ;
                    3'b001:  o_dec.mode = ALU_NE;
                    3'b100:  o_dec.mode = ALU_LT;
                    3'b101:  o_dec.mode = ALU_GE;
                    3'b110:  o_dec.mode = ALU_LTU;
                    3'b111:  o_dec.mode = ALU_GEU;
                    default: begin
                        o_dec.is_branch = 1'b0;
                        o_dec.illegal   = 1'b1;
                    end
                endcase
            end
            OPC_JAL: begin
                o_dec.a_sel   = A_PC;
                o_dec.b_sel   = B_FOUR;
                o_dec.rd_we   = 1'b1;
                o_dec.is_jump = 1'b1;
            end
            OPC_JALR: begin
                o_dec.rd_we   = 1'b1;
                o_dec.is_jump = 1'b1;
            end
            default: begin
                o_dec.a_sel   = A_ZERO;
                o_dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU initiator: accept one instruction, set up operands, pulse the mode,
// capture the ALU result with branch/jump resolution and hold it until consumed.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter logic [3:0] IDLE_MODE = ALU_IDLE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_mode,
    input  logic [XLEN-1:0] alu_x,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            rd_we,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            illegal
);

    state_t          r_state;
    logic [3:0]      r_mode;
    logic            r_dec_rd_we, r_is_branch, r_is_jump, r_is_jalr, r_dec_illegal;
    logic [XLEN-1:0] r_pc, r_imm, r_alu_a, r_alu_b;
    logic [XLEN-1:0] r_result, r_br_target;
    logic            r_rd_we, r_br_taken, r_illegal;

    dec_t            w_dec;
    logic [XLEN-1:0] w_a, w_b_raw, w_b, w_pc_imm, w_pc_4;
    logic            w_unused;

    assign w_unused = alu_zero;

    alu_decode u_decode (
        .i_opcode   (opcode),
        .i_funct3   (funct3),
        .i_funct7_5 (funct7_5),
        .o_dec      (w_dec)
    );

    always_comb begin
        w_a = rs1_val;
        case (w_dec.a_sel)
            A_PC:    w_a = pc;
            A_ZERO:  w_a = '0;
            default: w_a = rs1_val;
        endcase
        w_b_raw = imm;
        case (w_dec.b_sel)
            B_RS2:   w_b_raw = rs2_val;
            B_FOUR:  w_b_raw = XLEN'(4);
            default: w_b_raw = imm;
        endcase
        w_b = is_shift(w_dec.mode) ? {{(XLEN-5){1'b0}}, w_b_raw[4:0]} : w_b_raw;
    end

    assign w_pc_imm = r_pc + r_imm;
    assign w_pc_4   = r_pc + XLEN'(4);

    // Mode stays idle through SETUP so the ALU sees an idle->mode edge on every instruction.
    assign alu_mode  = (r_state == ST_EXEC || r_state == ST_DONE) ? r_mode : IDLE_MODE;
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign result    = r_result;
    assign rd_we     = r_rd_we;
    assign br_taken  = r_br_taken;
    assign br_target = r_br_target;
    assign illegal   = r_illegal;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mode        <= IDLE_MODE;
            r_dec_rd_we   <= 1'b0;
            r_is_branch   <= 1'b0;
            r_is_jump     <= 1'b0;
            r_is_jalr     <= 1'b0;
            r_dec_illegal <= 1'b0;
            r_pc          <= '0;
            r_imm         <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_result      <= '0;
            r_br_target   <= '0;
            r_rd_we       <= 1'b0;
            r_br_taken    <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mode        <= w_dec.mode;
                        r_dec_rd_we   <= w_dec.rd_we;
                        r_is_branch   <= w_dec.is_branch;
                        r_is_jump     <= w_dec.is_jump;
                        r_is_jalr     <= (opcode == OPC_JALR);
                        r_dec_illegal <= w_dec.illegal;
                        r_pc          <= pc;
                        r_imm         <= imm;
                        r_alu_a       <= w_a;
                        r_alu_b       <= w_b;
                        r_state       <= ST_SETUP;
                    end
                end
                ST_SETUP: r_state <= ST_EXEC;
                ST_EXEC: begin
                    r_illegal <= r_dec_illegal;
                    if (r_dec_illegal) begin
                        r_result    <= '0;
                        r_rd_we     <= 1'b0;
                        r_br_taken  <= 1'b0;
                        r_br_target <= '0;
                    end else if (r_is_jump) begin
                        r_result    <= w_pc_4;
                        r_rd_we     <= 1'b1;
                        r_br_taken  <= 1'b1;
                        r_br_target <= r_is_jalr ? (alu_x & ~XLEN'(1)) : w_pc_imm;
                    end else if (r_is_branch) begin
                        r_result    <= alu_x;
                        r_rd_we     <= 1'b0;
                        r_br_taken  <= alu_x[0];
                        r_br_target <= w_pc_imm;
                    end else begin
                        r_result    <= alu_x;
                        r_rd_we     <= r_dec_rd_we;
                        r_br_taken  <= 1'b0;
                        r_br_target <= '0;
                    end
                    r_state <= ST_DONE;
                end
                default: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Table-driven bench for alu_issue_ctrl with a behavioural ALU and an expected-result scoreboard.
module tb_alu_issue_ctrl;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] pc, rs1, rs2, imm;
        logic [3:0]  mode;      // 4'hF: mode not checked
        logic [31:0] res;
        logic        chk_res;
        logic        we, br;
        logic [31:0] tgt;
        logic        chk_tgt;
        logic        ill;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } sb_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7_5 = 1'b0;
    logic [31:0] pc = '0, rs1_val = '0, rs2_val = '0, imm = '0;
    logic [31:0] alu_a, alu_b, alu_x, result, br_target;
    logic [3:0]  alu_mode;
    logic        alu_zero, rd_we, br_taken, illegal;

    int   checks = 0, errors = 0, cyc = 0, rises = 0, n_sent = 0;
    logic seen = 1'b0;
    logic [3:0] prev_mode = 4'hF;
    sb_t  q[$];
    vec_t vecs[$];

    alu_issue_ctrl #(.XLEN(32), .IDLE_MODE(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .pc(pc),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_x(alu_x), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .rd_we(rd_we),
        .br_taken(br_taken), .br_target(br_target), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU beside the block
    always_comb begin
        alu_x = 32'hBAD0_BAD0;
        case (alu_mode)
            4'd0:  alu_x = alu_a + alu_b;
            4'd1:  alu_x = alu_a - alu_b;
            4'd2:  alu_x = alu_a & alu_b;
            4'd3:  alu_x = alu_a | alu_b;
            4'd4:  alu_x = alu_a ^ alu_b;
            4'd5:  alu_x = alu_a << alu_b[4:0];
            4'd6:  alu_x = alu_a >> alu_b[4:0];
            4'd7:  alu_x = $signed(alu_a) >>> alu_b[4:0];
            4'd8:  alu_x = {31'b0, alu_a < alu_b};
            4'd9:  alu_x = {31'b0, alu_a >= alu_b};
            4'd10: alu_x = {31'b0, alu_a == alu_b};
            4'd11: alu_x = {31'b0, alu_a != alu_b};
            4'd12: alu_x = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'd13: alu_x = {31'b0, $signed(alu_a) >= $signed(alu_b)};
            default: alu_x = 32'hBAD0_BAD0;
        endcase
    end
    assign alu_zero = (alu_x == 32'b0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic [31:0] vpc, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] vimm, input logic [3:0] mode,
                                input logic [31:0] res, input logic chk_res, input logic we,
                                input logic br, input logic [31:0] tgt, input logic chk_tgt,
                                input logic ill);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.f7 = f7; v.pc = vpc; v.rs1 = r1; v.rs2 = r2; v.imm = vimm;
        v.mode = mode; v.res = res; v.chk_res = chk_res; v.we = we; v.br = br;
        v.tgt = tgt; v.chk_tgt = chk_tgt; v.ill = ill;
        return v;
    endfunction

    // Scoreboard monitor: mode edge, latency and result checks, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_mode == 4'hF && alu_mode != 4'hF) begin
                rises <= rises + 1;
                if (q.size() > 0 && q[0].v.mode != 4'hF) check("alu_mode", {28'b0, alu_mode}, {28'b0, q[0].v.mode});
            end
            if (out_valid && !seen) begin
                seen <= 1'b1;
                if (q.size() > 0) check("latency", cyc - q[0].acc, 3);
            end
            if (out_valid && out_ready) begin
                seen <= 1'b0;
                if (q.size() == 0) begin
                    check("spurious_out", q.size(), 1);
                end else begin
                    sb_t e;
                    e = q.pop_front();
                    if (e.v.chk_res) check("result", result, e.v.res);
                    check("rd_we", {31'b0, rd_we}, {31'b0, e.v.we});
                    check("br_taken", {31'b0, br_taken}, {31'b0, e.v.br});
                    if (e.v.chk_tgt) check("br_target", br_target, e.v.tgt);
                    check("illegal", {31'b0, illegal}, {31'b0, e.v.ill});
                end
            end
        end
        prev_mode <= alu_mode;
    end

    task automatic send(input vec_t v);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        opcode = v.opc; funct3 = v.f3; funct7_5 = v.f7; pc = v.pc;
        rs1_val = v.rs1; rs2_val = v.rs2; imm = v.imm; in_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (in_ready) begin
                sb_t e;
                e.v = v; e.acc = cyc;
                q.push_back(e);
                n_sent++;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("in_ready_timeout", {31'b0, in_ready}, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
        check("drain_timeout", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        // opc, f3, f7, pc, rs1, rs2, imm, mode, res, chk_res, we, br, tgt, chk_tgt, ill
        vecs.push_back(mk(7'h33, 3'd0, 1'b0, 32'h0, 32'd5, 32'd7, 32'h0, 4'd0, 32'd12, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h33, 3'd0, 1'b1, 32'h0, 32'd10, 32'd3, 32'h0, 4'd1, 32'd7, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h33, 3'd0, 1'b1, 32'h0, 32'd20, 32'd5, 32'h0, 4'd1, 32'd15, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h63, 3'd4, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 4'd12, 32'h0, 0, 0, 1, 32'h120, 1, 0));
        vecs.push_back(mk(7'h63, 3'd6, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 4'd8, 32'h0, 0, 0, 0, 32'h120, 1, 0));
        vecs.push_back(mk(7'h67, 3'd0, 1'b0, 32'h40, 32'h1001, 32'h0, 32'd4, 4'd0, 32'h44, 1, 1, 1, 32'h1004, 1, 0));
        vecs.push_back(mk(7'h13, 3'd5, 1'b1, 32'h0, 32'h8000_0000, 32'h0, 32'h404, 4'd7, 32'hF800_0000, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h7F, 3'd0, 1'b0, 32'h0, 32'd9, 32'd9, 32'd9, 4'hF, 32'h0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(7'h6F, 3'd0, 1'b0, 32'h200, 32'h0, 32'h0, 32'hFFFF_FFF0, 4'd0, 32'h204, 1, 1, 1, 32'h1F0, 1, 0));
        vecs.push_back(mk(7'h37, 3'd0, 1'b0, 32'h50, 32'hFFFF, 32'h0, 32'h1234_5000, 4'd0, 32'h1234_5000, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h17, 3'd0, 1'b0, 32'h1000, 32'hFFFF, 32'h0, 32'h2000, 4'd0, 32'h3000, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h03, 3'd2, 1'b0, 32'h0, 32'h100, 32'h0, 32'hFFFF_FFFC, 4'd0, 32'hFC, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h23, 3'd2, 1'b0, 32'h0, 32'h100, 32'h55, 32'd8, 4'd0, 32'h108, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(7'h33, 3'd1, 1'b0, 32'h0, 32'd1, 32'h23, 32'h0, 4'd5, 32'd8, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h33, 3'd2, 1'b0, 32'h0, 32'hFFFF_FFFE, 32'd1, 32'h0, 4'd12, 32'd1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h33, 3'd3, 1'b0, 32'h0, 32'hFFFF_FFFE, 32'd1, 32'h0, 4'd8, 32'd0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h33, 3'd5, 1'b0, 32'h0, 32'h8000_0000, 32'd31, 32'h0, 4'd6, 32'd1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h33, 3'd6, 1'b0, 32'h0, 32'hF0, 32'h0F, 32'h0, 4'd3, 32'hFF, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h13, 3'd4, 1'b0, 32'h0, 32'hFF, 32'h0, 32'h0F, 4'd4, 32'hF0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h13, 3'd7, 1'b0, 32'h0, 32'hF0F0, 32'h0, 32'hFF, 4'd2, 32'hF0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h13, 3'd0, 1'b1, 32'h0, 32'd10, 32'h0, 32'h400, 4'd0, 32'h40A, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h13, 3'd0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'd1, 4'd0, 32'h0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(7'h63, 3'd1, 1'b0, 32'h80, 32'd3, 32'd3, 32'd8, 4'd11, 32'h0, 0, 0, 0, 32'h88, 1, 0));
        vecs.push_back(mk(7'h63, 3'd7, 1'b0, 32'h0, 32'd5, 32'd5, 32'h10, 4'd9, 32'h0, 0, 0, 1, 32'h10, 1, 0));
        vecs.push_back(mk(7'h63, 3'd0, 1'b0, 32'h300, 32'd7, 32'd7, 32'hFFFF_FF00, 4'd10, 32'h0, 0, 0, 1, 32'h200, 1, 0));
        vecs.push_back(mk(7'h63, 3'd2, 1'b0, 32'h300, 32'd7, 32'd7, 32'h40, 4'hF, 32'h0, 1, 0, 0, 0, 0, 1));

        #2;
        check("rst_in_ready", {31'b0, in_ready}, 1);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_mode", {28'b0, alu_mode}, 32'hF);
        check("rst_result", result, 0);
        check("rst_rd_we", {31'b0, rd_we}, 0);
        check("rst_br_taken", {31'b0, br_taken}, 0);
        check("rst_br_target", br_target, 0);
        check("rst_illegal", {31'b0, illegal}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) send(vecs[i]);
        drain();

        // Consumer stall: outputs held, nothing new accepted
        out_ready = 1'b0;
        send(mk(7'h33, 3'd0, 1'b0, 32'h0, 32'd100, 32'd23, 32'h0, 4'd0, 32'd123, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("stall_reach_done", {31'b0, out_valid}, 1);
        @(posedge clk); #1;
        opcode = 7'h33; funct3 = 3'd0; funct7_5 = 1'b0; rs1_val = 32'd1; rs2_val = 32'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", {31'b0, out_valid}, 1);
            check("stall_in_ready", {31'b0, in_ready}, 0);
            check("stall_result", result, 32'd123);
            check("stall_alu_mode", {28'b0, alu_mode}, 32'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset while the ALU is being driven abandons the instruction
        send(vecs[0]);
        @(posedge clk); #1;
        check("pre_rst_mode_exec", {28'b0, alu_mode}, 32'd0);
        rst_n = 1'b0;
        void'(q.pop_back());
        n_sent--;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 0);
        check("abort_in_ready", {31'b0, in_ready}, 1);
        check("abort_alu_mode", {28'b0, alu_mode}, 32'hF);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("abort_no_output", {31'b0, out_valid}, 0);

        send(vecs[1]);
        drain();
        check("mode_rises", rises, n_sent);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage initiator for the ALU: takes one decoded instruction per valid/ready handshake and translates opcode/funct fields into ALU operands and the 4-bit ALU mode.
- Drives the ALU, waits for its result, then registers it together with branch/jump resolution.
- Sits between the decode pipeline register and writeback/PC-select logic; the ALU itself stays combinational and is instantiated beside this block.

Parameters:
- XLEN, 32, datapath width.
- IDLE_MODE, 4'hF, ALU mode code with no operation; the ALU holds X while it is driven.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction available.
- in_ready  out  1  block can accept; high only in IDLE.
- opcode  in  7  RV32I opcode.
- funct3  in  3  RV32I funct3.
- funct7_5  in  1  instr[30].
- pc  in  XLEN  instruction address.
- rs1_val  in  XLEN  source 1.
- rs2_val  in  XLEN  source 2.
- imm  in  XLEN  sign-extended immediate.
- alu_a  out  XLEN  ALU operand A.
- alu_b  out  XLEN  ALU operand B.
- alu_mode  out  4  ALU mode.
- alu_x  in  XLEN  ALU result.
- alu_zero  in  1  ALU zero flag (unused for decisions; exported only).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- result  out  XLEN  rd write value.
- rd_we  out  1  instruction writes rd.
- br_taken  out  1  redirect PC.
- br_target  out  XLEN  redirect address.
- illegal  out  1  opcode not supported.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - Outputs: in_ready=1, out_valid=0, alu_a=0, alu_b=0, alu_mode=IDLE_MODE, result=0, rd_we=0, br_taken=0, br_target=0, illegal=0.
  - Reset mid-operation abandons the instruction; nothing is emitted.
- States IDLE -> SETUP -> EXEC -> DONE -> IDLE.
- IDLE: on in_valid&&in_ready, latch all inputs and the decoded mode/operand selects. Go to SETUP.
- SETUP (1 cycle):
  - alu_a and alu_b are driven with final values; alu_mode=IDLE_MODE.
  - Operands must be stable before mode leaves IDLE_MODE. The ALU re-evaluates only on a mode change, so back-to-back identical modes still recompute.
- EXEC (1 cycle):
  - alu_mode = decoded mode. At the end of the cycle, register alu_x into result/branch logic.
  - Go to DONE.
- DONE:
  - out_valid=1; all result outputs are held stable until out_ready.
  - On out_ready: out_valid drops next cycle, alu_mode returns to IDLE_MODE, go to IDLE.
- Latency:
  - Accept in cycle 0 gives out_valid in cycle 3.
  - With out_ready held high, throughput is one instruction per 4 cycles.
  - in_ready is high only in IDLE; simultaneous in_valid during DONE is not accepted.
- Decode (mode codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 ltu, 9 geu, 10 eq, 11 ne, 12 lt, 13 ge):
  - OP (0110011), A=rs1, B=rs2; OP-IMM (0010011), A=rs1, B=imm. funct3 mapping:
    - 000: add; sub only for OP with funct7_5=1.
    - 001: sll.
    - 010: lt.
    - 011: ltu.
    - 100: xor.
    - 101: srl, or sra if funct7_5=1.
    - 110: or.
    - 111: and.
  - Shift B is masked to B[4:0] zero-extended.
  - LUI: A=0, B=imm, add. AUIPC: A=pc, B=imm, add.
  - LOAD/STORE: A=rs1, B=imm, add; result=address; rd_we=1 for LOAD only.
  - BRANCH: A=rs1, B=rs2; funct3 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu.
    - br_taken = alu_x[0]; br_target = pc+imm (block-internal adder); rd_we=0.
    - funct3 010/011 are illegal.
  - JAL: ALU add pc+4; result = pc+4; br_taken=1; br_target = pc+imm.
  - JALR: ALU add rs1+imm; br_target = alu_x & ~1; result = pc+4; br_taken=1.
  - Any other opcode:
    - illegal=1, rd_we=0, br_taken=0, result=0.
    - The state sequence and latency are unchanged.
- Arithmetic: all adds are modulo 2^XLEN; overflow is ignored.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_ADD..ALU_GE and ALU_IDLE constants.
  - Opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR.
  - State enum.
- One combinational sub-module, alu_decode: fields -> {mode, a_sel, b_sel, rd_we, is_branch, is_jump, illegal}.

Test Plan:
- OP add, rs1=5, rs2=7, funct7_5=0 -> alu_mode 0 in EXEC, out_valid cycle 3, result=12, rd_we=1.
- Two back-to-back SUB 10-3 then 20-5 -> mode passes IDLE_MODE between them; results 7 then 15.
- BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> br_taken=1, br_target=0x120. Same operands with BLTU -> br_taken=0.
- JALR rs1=0x1001, imm=4, pc=0x40 -> br_target=0x1004, result=0x44, rd_we=1.
- SRAI rs1=0x80000000, imm=0x404 (funct7_5=1, B masked to 4) -> result=0xF8000000.
- Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Assert rst_n=0 in EXEC -> out_valid=0, in_ready=1 immediately. Opcode 0x7F -> illegal=1, result=0.
